// File: rtl/conv_uart_pkg.sv
// Shared definitions for the convolution UART link (transmit and receive sides).
// Optional feature macro: TX_PARITY_EN adds an even-parity bit after the data bits.
package conv_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DEF_BAUD_DIV   = 868;
  localparam int DEF_OUTSIZE    = 250000;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DATA_BITS      = 8;

`ifdef TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_serializer.sv
// Byte-to-UART serializer: FSM, baud counter and shift register.
// A byte is taken when byte_rdy is high (FSM leaving IDLE or ending STOP with data waiting).
// done pulses on the last cycle of STOP. tx is registered one cycle behind the FSM.
// Optional feature macro: TX_PARITY_EN inserts an even-parity bit after bit 7.
module uart_tx_serializer
  import conv_uart_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] byte_in,
  input  logic       byte_vld,
  output logic       byte_rdy,
  output logic       tx,
  output logic       done,
  output logic       idle
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  tx_state_t  state;
  tx_state_t  state_nxt;
  logic [BW-1:0] baud_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  logic       bit_end;
  logic       tx_nxt;
`ifdef TX_PARITY_EN
  logic       parity_bit;
`endif

  assign bit_end = (baud_cnt == BAUD_LAST);

  // State register; en low forces the FSM back to IDLE, aborting any frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (!en) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Baud counter, shift register and registered tx line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
`ifdef TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (!en) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
`ifdef TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx <= tx_nxt;
      if (state == IDLE || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
      if (byte_rdy) begin
        shift_reg <= byte_in;
        bit_idx   <= '0;
`ifdef TX_PARITY_EN
        parity_bit <= ^byte_in;
`endif
      end else if (state == DATA && bit_end) begin
        shift_reg <= shift_reg >> 1;
        bit_idx   <= bit_idx + 1'b1;
      end
    end
  end

  // Next-state logic: each bit lasts exactly BAUD_DIV cycles, STOP chains into START when data waits
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (byte_vld) state_nxt = START;
      START:  if (bit_end) state_nxt = DATA;
      DATA:   if (bit_end && bit_idx == 3'd7) begin
`ifdef TX_PARITY_EN
                state_nxt = PARITY;
`else
                state_nxt = STOP;
`endif
              end
      PARITY: if (bit_end) state_nxt = STOP;
      STOP:   if (bit_end) state_nxt = byte_vld ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: byte acceptance, end-of-frame pulse and the next tx level
  always_comb begin
    byte_rdy = en && byte_vld && (state == IDLE || (state == STOP && bit_end));
    done     = en && (state == STOP) && bit_end;
    idle     = (state == IDLE);
    tx_nxt   = 1'b1;
    case (state)
      START:  tx_nxt = 1'b0;
      DATA:   tx_nxt = shift_reg[0];
`ifdef TX_PARITY_EN
      PARITY: tx_nxt = parity_bit;
`else
      PARITY: tx_nxt = 1'b1;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: rtl/send_pixel.sv
// UART transmit side of the convolution link: pixel FIFO, valid/ready intake,
// sent/accepted byte counters and the sticky finished flag around uart_tx_serializer.
// Optional feature macro: TX_PARITY_EN (even parity bit, 11-bit frame).
module send_pixel
  import conv_uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEF_BAUD_DIV,
  parameter int OUTSIZE    = DEF_OUTSIZE,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  pix_in,
  input  logic        pix_vld,
  output logic        pix_rdy,
  output logic        tx,
  output logic        busy,
  output logic        finished,
  output logic [31:0] sent_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] OUT_LIMIT = 32'(OUTSIZE);

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic [31:0] acc_cnt;
  logic        ser_done;
  logic        ser_idle;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pix_rdy    = en && !fifo_full && (acc_cnt < OUT_LIMIT);
  assign push       = pix_vld && pix_rdy;
  assign busy       = !finished && (!ser_idle || !fifo_empty);

  // FIFO storage; contents are don't-care once the pointers are cleared
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= pix_in;
    end
  end

  // FIFO pointers; the extra MSB separates full from empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (!en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Accepted/sent counters and finished flag; intake stops once a full image is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt  <= '0;
      sent_cnt <= '0;
      finished <= 1'b0;
    end else if (!en) begin
      acc_cnt  <= '0;
      sent_cnt <= '0;
      finished <= 1'b0;
    end else begin
      if (push) acc_cnt <= acc_cnt + 1'b1;
      if (ser_done) begin
        sent_cnt <= sent_cnt + 1'b1;
        if (sent_cnt == OUT_LIMIT - 32'd1) finished <= 1'b1;
      end
    end
  end

  uart_tx_serializer #(
    .BAUD_DIV (BAUD_DIV)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .byte_in  (fifo_mem[rd_ptr[AW-1:0]]),
    .byte_vld (!fifo_empty),
    .byte_rdy (pop),
    .tx       (tx),
    .done     (ser_done),
    .idle     (ser_idle)
  );

endmodule

// File: tb/tb_send_pixel.sv
// Self-checking bench for send_pixel: accepted bytes go into a scoreboard queue,
// an independent line decoder samples tx mid-bit and compares whole frames.
// Optional feature macro: TX_PARITY_EN (bench expects the parity bit when defined).
module tb_send_pixel;

  localparam int BAUD_DIV   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int OUTSIZE    = 8;
`ifdef TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC  = FRAME_BITS * BAUD_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  pix_in = 8'h00;
  logic        pix_vld = 1'b0;
  logic        pix_rdy;
  logic        tx;
  logic        busy;
  logic        finished;
  logic [31:0] sent_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic check_gap = 1'b0;

  always #5 clk = ~clk;

  send_pixel #(
    .BAUD_DIV   (BAUD_DIV),
    .OUTSIZE    (OUTSIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pix_in   (pix_in),
    .pix_vld  (pix_vld),
    .pix_rdy  (pix_rdy),
    .tx       (tx),
    .busy     (busy),
    .finished (finished),
    .sent_cnt (sent_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line-level view of a byte: start 0, data LSB first, optional even parity, stop 1
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef TX_PARITY_EN
    f[9]  = ^b;
    f[10] = 1'b1;
`else
    f[9]  = 1'b1;
`endif
    return f;
  endfunction

  // Line decoder: detects a start edge, samples each bit at its centre, checks against scoreboard
  int mon_cnt = 0;
  logic mon_active = 1'b0;
  logic [10:0] mon_bits = '1;
  int cyc = 0;
  int last_start = -1;
  logic [7:0] mon_exp;
  logic [10:0] mon_exp_frame;

  always @(negedge clk) begin
    cyc++;
    if (!en || !rst) begin
      mon_active = 1'b0;
      last_start = -1;
    end else begin
      if (!mon_active && tx == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_bits   = '1;
        if (check_gap && last_start >= 0) checkOutput("frame_gap", cyc - last_start, FRAME_CYC);
        last_start = check_gap ? cyc : -1;
      end
      if (mon_active) begin
        if (mon_cnt % BAUD_DIV == BAUD_DIV / 2) mon_bits[mon_cnt / BAUD_DIV] = tx;
        if (mon_cnt == (FRAME_BITS - 1) * BAUD_DIV + BAUD_DIV / 2) begin
          mon_active = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_frame: got frame 0x%0h, expected no frame", mon_bits);
          end else begin
            mon_exp       = exp_q.pop_front();
            mon_exp_frame = frame_of(mon_exp);
            checkOutput("frame", 32'(mon_bits), 32'(mon_exp_frame));
          end
        end
        mon_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte until accepted or max_wait cycles pass; accepted bytes enter the scoreboard
  task automatic applyStimulus(input logic [7:0] b, input int max_wait, output logic ok, output int waited);
    pix_in  = b;
    pix_vld = 1'b1;
    ok      = 1'b0;
    waited  = 0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (pix_rdy) ok = 1'b1;
      else waited++;
      @(posedge clk);
      #1;
      if (ok) exp_q.push_back(b);
    end
    pix_vld = 1'b0;
  endtask

  task automatic clear_block();
    en = 1'b0;
    step();
    @(negedge clk);
    checkOutput("clr_tx", 32'(tx), 32'd1);
    checkOutput("clr_rdy", 32'(pix_rdy), 32'd0);
    checkOutput("clr_sent", sent_cnt, 32'd0);
    checkOutput("clr_finished", 32'(finished), 32'd0);
    checkOutput("clr_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    en = 1'b1;
    step();
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", max_cycles);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic ok;
    int waited;
    int n;
    int acc;
    logic [7:0] b;
    logic [10:0] f;

    // Reset held, then released with en still low
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_rdy", 32'(pix_rdy), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_finished", 32'(finished), 32'd0);
    checkOutput("rst_sent", sent_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    checkOutput("en0_tx", 32'(tx), 32'd1);
    checkOutput("en0_rdy", 32'(pix_rdy), 32'd0);
    checkOutput("en0_busy", 32'(busy), 32'd0);

    // Single byte 0xA5: exact cycle-by-cycle line waveform relative to the push edge
    @(posedge clk);
    #1;
    en = 1'b1;
    step();
    pix_in  = 8'hA5;
    pix_vld = 1'b1;
    @(negedge clk);
    checkOutput("a5_rdy", 32'(pix_rdy), 32'd1);
    @(posedge clk);
    exp_q.push_back(8'hA5);
    #1;
    pix_vld = 1'b0;
    f = frame_of(8'hA5);
    for (int c = 0; c <= FRAME_CYC + 2; c++) begin
      @(negedge clk);
      if (c < 2 || c == FRAME_CYC + 2) checkOutput("a5_line_idle", 32'(tx), 32'd1);
      else checkOutput("a5_line_bit", 32'(tx), 32'(f[(c - 2) / BAUD_DIV]));
      if (c == 2) checkOutput("a5_sent_before", sent_cnt, 32'd0);
      if (c == 1) checkOutput("a5_busy", 32'(busy), 32'd1);
    end
    checkOutput("a5_sent_after", sent_cnt, 32'd1);
    @(posedge clk);
    #1;

    // Burst of 10 bytes with valid held: FIFO fills, frames abut, only OUTSIZE accepted
    clear_block();
    check_gap = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      applyStimulus(b, (i < 8) ? 60 : 100, ok, waited);
      if (ok) acc++;
      if (i < 5) checkOutput("burst_immediate", 32'(waited), 32'd0);
      if (i >= 8) checkOutput("burst_refused", 32'(ok), 32'd0);
      if (i == 4) begin
        pix_vld = 1'b1;
        @(negedge clk);
        checkOutput("burst_full_rdy", 32'(pix_rdy), 32'd0);
      end
    end
    checkOutput("burst_accepted", acc, 32'(OUTSIZE));
    n = 0;
    @(negedge clk);
    while (!finished && n < OUTSIZE * FRAME_CYC + 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("burst_finished", 32'(finished), 32'd1);
    checkOutput("burst_sent_at_finish", sent_cnt, 32'(OUTSIZE));
    checkOutput("burst_busy_at_finish", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("burst_finished_sticky", 32'(finished), 32'd1);
    checkOutput("burst_rdy_after", 32'(pix_rdy), 32'd0);
    checkOutput("burst_scoreboard_empty", exp_q.size(), 32'd0);
    check_gap = 1'b0;
    @(posedge clk);
    #1;

    // Drop en in the data bits of the second frame, then send a clean 0x3C
    clear_block();
    applyStimulus(8'($urandom), 20, ok, waited);
    applyStimulus(8'($urandom), 20, ok, waited);
    n = 0;
    @(negedge clk);
    while (sent_cnt != 32'd1 && n < 2 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_first_sent", sent_cnt, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_tx", 32'(tx), 32'd1);
    checkOutput("abort_sent", sent_cnt, 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    en = 1'b1;
    step();
    applyStimulus(8'h3C, 20, ok, waited);
    checkOutput("reen_accept", 32'(ok), 32'd1);
    wait_idle(3 * FRAME_CYC);
    checkOutput("reen_sent", sent_cnt, 32'd1);
    checkOutput("reen_scoreboard_empty", exp_q.size(), 32'd0);

    // Random rounds with random gaps, including the parity examples 0x07 and 0x03
    for (int r = 0; r < 3; r++) begin
      clear_block();
      n = (r == 2) ? OUTSIZE : int'($urandom_range(2, OUTSIZE - 1));
      acc = 0;
      for (int i = 0; i < n; i++) begin
        if (r == 0 && i == 0) b = 8'h07;
        else if (r == 0 && i == 1) b = 8'h03;
        else b = 8'($urandom);
        repeat ($urandom_range(0, 3) * (($urandom_range(0, 3) == 0) ? 20 : 1)) step();
        applyStimulus(b, 100, ok, waited);
        if (ok) acc++;
      end
      checkOutput("rand_accepted", acc, n);
      wait_idle(OUTSIZE * FRAME_CYC + 100);
      checkOutput("rand_sent", sent_cnt, 32'(n));
      checkOutput("rand_finished", 32'(finished), (n == OUTSIZE) ? 32'd1 : 32'd0);
      checkOutput("rand_scoreboard_empty", exp_q.size(), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
